// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its step datapath.
package shift_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned AMT_W    = 8;
   localparam int unsigned STEP_W   = 3;
   localparam int unsigned STEP_MAX = 7;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROR = 2'b11
   } shift_op_t;

   // Sequencer state encoding kept as plain constants
   typedef logic [1:0] seq_state_t;
   localparam seq_state_t ST_IDLE  = 2'd0;
   localparam seq_state_t ST_SHIFT = 2'd1;
   localparam seq_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between a client and the shift sequencer.
interface shift_sequencer_if;
   import shift_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   shift_op_t             req_op;
   logic [DATA_W-1:0]     req_data;
   logic [AMT_W-1:0]      req_amt;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_data;
   logic                  rsp_zero;
   logic                  busy;

   modport master (
      output req_valid, req_op, req_data, req_amt, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_zero, busy
   );

   modport slave (
      input  req_valid, req_op, req_data, req_amt, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_zero, busy
   );

endinterface

// File: rtl/shift_step_8bit.sv
// Combinational 0..7-step shifter built from 4/2/1 mux stages.
module shift_step_8bit
   import shift_pkg::*;
(
   input  shift_op_t         op_i,
   input  logic [7:0]        data_i,
   input  logic [STEP_W-1:0] amt_i,
   output logic [7:0]        shifted_c_o
);

   logic [7:0] s4_c;
   logic [7:0] s2_c;

   // One fixed-distance shift of the selected kind
   function automatic logic [7:0] stage(input shift_op_t op, input logic [7:0] d,
                                        input int unsigned k);
      case (op)
         OP_LSL:  return d << k;
         OP_LSR:  return d >> k;
         OP_ASR:  return 8'($signed(d) >>> k);
         default: return (d >> k) | (d << (8 - k));
      endcase
   endfunction

   // Cascade: bit 2 selects a 4-shift, bit 1 a 2-shift, bit 0 a 1-shift
   always_comb begin
      s4_c        = amt_i[2] ? stage(op_i, data_i, 4) : data_i;
      s2_c        = amt_i[1] ? stage(op_i, s4_c, 2)   : s4_c;
      shifted_c_o = amt_i[0] ? stage(op_i, s2_c, 1)   : s2_c;
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts a request, iterates the step shifter
// until the full amount is consumed, then holds the result for the consumer.
// Optional macro SHIFT_FASTPATH_EN reduces large amounts at accept time.
module shift_sequencer
   import shift_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_N,
   shift_sequencer_if.slave bus
);

   seq_state_t          state_q, state_d;
   shift_op_t           op_q, op_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [AMT_W-1:0]    rem_q, rem_d;
   logic                req_ready_q, rsp_valid_q, busy_q, zero_q;
   logic [STEP_W-1:0]   step_c;
   logic [DATA_W-1:0]   stepped_c;

   // Largest step the datapath can take without overrunning the remainder
   assign step_c = (rem_q > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];

   shift_step_8bit u_step (
      .op_i        (op_q),
      .data_i      (data_q),
      .amt_i       (step_c),
      .shifted_c_o (stepped_c)
   );

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               op_d   = bus.req_op;
               data_d = bus.req_data;
               rem_d  = bus.req_amt;
`ifdef SHIFT_FASTPATH_EN
               if (bus.req_amt >= AMT_W'(DATA_W)) begin
                  case (bus.req_op)
                     OP_LSL, OP_LSR: begin
                        data_d = '0;
                        rem_d  = '0;
                     end
                     OP_ASR:  rem_d = AMT_W'(STEP_MAX);
                     default: rem_d = AMT_W'(bus.req_amt[STEP_W-1:0]);
                  endcase
               end
`endif
               state_d = (rem_d == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = stepped_c;
            rem_d  = rem_q - AMT_W'(step_c);
            if (rem_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_LSL;
         data_q      <= '0;
         rem_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         rem_q       <= rem_d;
         req_ready_q <= (state_d == ST_IDLE);
         rsp_valid_q <= (state_d == ST_DONE);
         busy_q      <= (state_d != ST_IDLE);
         zero_q      <= (data_d == '0);
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_zero  = zero_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// transactions against a behavioural model. Honours SHIFT_FASTPATH_EN.
module tb_shift_sequencer;
   import shift_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Exact N-bit shift result
   function automatic logic [7:0] ref_result(input shift_op_t op, input logic [7:0] d,
                                             input int n);
      logic [15:0] dd;
      case (op)
         OP_LSL:  return (n >= 8) ? 8'h00 : 8'(d << n);
         OP_LSR:  return (n >= 8) ? 8'h00 : 8'(d >> n);
         OP_ASR:  return (n >= 8) ? {8{d[7]}} : 8'($signed(d) >>> n);
         default: begin
            dd = {d, d};
            return 8'(dd >> (n % 8));
         end
      endcase
   endfunction

   // Cycles from accept edge to first rsp_valid cycle
   function automatic int ref_latency(input shift_op_t op, input int n);
      int eff;
      eff = n;
`ifdef SHIFT_FASTPATH_EN
      if (n >= 8) begin
         if (op == OP_LSL || op == OP_LSR) eff = 0;
         else if (op == OP_ASR)            eff = 7;
         else                              eff = n % 8;
      end
`endif
      return 1 + (eff + 6) / 7;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         cyc();
         guard++;
      end
      check("req_ready_before_issue", bus.req_ready, 1);
   endtask

   task automatic issue(input shift_op_t op, input logic [7:0] d, input logic [7:0] n);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      bus.req_amt   = n;
      cyc();
      bus.req_valid = 1'b0;
   endtask

   // Full transaction: issue, measure latency, apply backpressure, retire
   task automatic run_txn(input shift_op_t op, input logic [7:0] d, input logic [7:0] n,
                          input logic [7:0] exp_d, input int exp_lat,
                          input int hold, input bit poke);
      int lat;
      wait_ready();
      issue(op, d, n);
      if (poke) begin
         bus.req_valid = 1'b1;
         bus.req_op    = OP_LSL;
         bus.req_data  = ~d;
         bus.req_amt   = 8'd0;
      end
      lat = 1;
      while (!bus.rsp_valid && lat < 300) begin
         if (poke) check("req_ready_during_shift", bus.req_ready, 0);
         cyc();
         lat++;
      end
      check("latency", lat, exp_lat);
      check("rsp_data", bus.rsp_data, exp_d);
      check("rsp_zero", bus.rsp_zero, (exp_d == 8'h00));
      check("busy_in_done", bus.busy, 1);
      for (int i = 0; i < hold; i++) begin
         cyc();
         check("rsp_valid_held", bus.rsp_valid, 1);
         check("rsp_data_held", bus.rsp_data, exp_d);
         if (poke) check("req_ready_during_done", bus.req_ready, 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      check("rsp_valid_after_take", bus.rsp_valid, 0);
      check("busy_after_take", bus.busy, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_data", bus.rsp_data, 8'h00);
      check("rst_rsp_zero", bus.rsp_zero, 1);
   endtask

   initial begin
      shift_op_t   op;
      logic [7:0]  d;
      logic [7:0]  n;
      int          r;

      bus.req_valid = 1'b0;
      bus.req_op    = OP_LSL;
      bus.req_data  = 8'h00;
      bus.req_amt   = 8'h00;
      bus.rsp_ready = 1'b0;

      repeat (3) cyc();
      check_reset_outputs();
      rst_n = 1'b1;
      cyc();

      // Directed cases with spec-given results
      run_txn(OP_LSR, 8'h80, 8'd4, 8'h08, 2, 0, 1'b0);
`ifdef SHIFT_FASTPATH_EN
      run_txn(OP_ASR, 8'h80, 8'd9,   8'hFF, 2, 0, 1'b0);
      run_txn(OP_LSL, 8'hFF, 8'd255, 8'h00, 1, 0, 1'b0);
`else
      run_txn(OP_ASR, 8'h80, 8'd9,   8'hFF, 3,  0, 1'b0);
      run_txn(OP_LSL, 8'hFF, 8'd255, 8'h00, 38, 0, 1'b0);
`endif
      run_txn(OP_ROR, 8'h81, 8'd1, 8'hC0, 2, 0, 1'b0);
      run_txn(OP_ROR, 8'h81, 8'd8, 8'h81, ref_latency(OP_ROR, 8), 0, 1'b0);
      run_txn(OP_LSL, 8'h5A, 8'd0, 8'h5A, 1, 0, 1'b0);
      run_txn(OP_ASR, 8'hA5, 8'd0, 8'hA5, 1, 0, 1'b0);
      run_txn(OP_LSL, 8'h01, 8'd7, 8'h80, 2, 0, 1'b0);
      run_txn(OP_LSR, 8'hF0, 8'd8, 8'h00, ref_latency(OP_LSR, 8), 0, 1'b0);

      // Backpressure with requests poked while busy
      run_txn(OP_LSL, 8'h03, 8'd20, 8'h00, ref_latency(OP_LSL, 20), 5, 1'b1);
      run_txn(OP_ROR, 8'h3C, 8'd10, 8'h0F, ref_latency(OP_ROR, 10), 5, 1'b1);

      // Asynchronous reset while a long shift is in flight
      wait_ready();
      issue(OP_LSL, 8'hFF, 8'd100);
      repeat (3) cyc();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      cyc();
      rst_n = 1'b1;
      cyc();
      run_txn(OP_LSR, 8'h40, 8'd6, 8'h01, 2, 0, 1'b0);

      // Randomized traffic against the model
      for (int t = 0; t < 2000; t++) begin
         op = shift_op_t'($urandom_range(0, 3));
         d  = 8'($urandom);
         r  = int'($urandom_range(0, 3));
         if (r == 0)      n = 8'($urandom_range(0, 9));
         else if (r == 1) n = 8'($urandom);
         else             n = 8'($urandom_range(0, 30));
         run_txn(op, d, n, ref_result(op, d, int'(n)), ref_latency(op, int'(n)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
